// File: rtl/lpc_mailbox_pkg.sv
// lpc_mailbox_pkg: register offsets, register bit positions and handshake FSM states
package lpc_mailbox_pkg;
    localparam logic [1:0] LPC_MBOX_OFS_DATA   = 2'd0;
    localparam logic [1:0] LPC_MBOX_OFS_STATUS = 2'd1;
    localparam logic [1:0] LPC_MBOX_OFS_CTRL   = 2'd2;
    localparam logic [1:0] LPC_MBOX_OFS_IRQ    = 2'd3;
    localparam int LPC_MBOX_STATUS_TXNE   = 0;
    localparam int LPC_MBOX_STATUS_RXFULL = 1;
    localparam int LPC_MBOX_STATUS_OVR    = 2;
    localparam int LPC_MBOX_CTRL_IEN      = 0;
    localparam int LPC_MBOX_CTRL_FLUSH    = 1;
    typedef enum logic [1:0] {
        LPC_MBOX_ST_IDLE   = 2'd0,
        LPC_MBOX_ST_WR_ACK = 2'd1,
        LPC_MBOX_ST_RD_ACK = 2'd2
    } lpc_mbox_state_e;
endpackage

// File: rtl/lpc_mbox_fifo.sv
// lpc_mbox_fifo: synchronous first-word-fall-through byte FIFO with flush
module lpc_mbox_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                   clk_i,
    input  logic                   nrst_i,
    input  logic                   push_i,
    input  logic [7:0]             data_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output logic [7:0]             data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);
    logic [7:0] mem [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic do_push, do_pop;
    always_comb begin
        full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        empty_o  = wr_ptr_q == rd_ptr_q;
        count_o  = wr_ptr_q - rd_ptr_q;
        data_o   = empty_o ? 8'h00 : mem[rd_ptr_q[AW-1:0]];
        do_pop   = pop_i && !empty_o;
        do_push  = push_i && (!full_o || do_pop);
        wr_ptr_d = flush_i ? '0 : wr_ptr_q + (AW+1)'(do_push);
        rd_ptr_d = flush_i ? '0 : rd_ptr_q + (AW+1)'(do_pop);
    end
    always_ff @(posedge clk_i) begin
        if (!nrst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem[wr_ptr_q[AW-1:0]] <= data_i;
    end
endmodule

// File: rtl/lpc_mailbox.sv
// lpc_mailbox: LPC I/O window exposing a host<->local byte mailbox with status, control and SERIRQ
module lpc_mailbox
    import lpc_mailbox_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR   = 16'h0E00,
    parameter int          FIFO_DEPTH  = 16,
    parameter logic [3:0]  IRQ_DEFAULT = 4'd5
) (
    input  logic        clk_i,
    input  logic        nrst_i,
    input  logic [15:0] lpc_addr_i,
    input  logic [7:0]  lpc_wdata_i,
    input  logic        lpc_data_wr_i,
    output logic        lpc_wr_done_o,
    input  logic        lpc_data_req_i,
    output logic [7:0]  lpc_rdata_o,
    output logic        lpc_data_rd_o,
    output logic [3:0]  irq_num_o,
    output logic        interrupt_o,
    input  logic [7:0]  tx_data_i,
    input  logic        tx_valid_i,
    output logic        tx_ready_o,
    output logic [7:0]  rx_data_o,
    output logic        rx_valid_o,
    input  logic        rx_ready_i
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    lpc_mbox_state_e state_q, state_d;
    logic wr_done_q, wr_done_d, data_rd_q, data_rd_d;
    logic ien_q, ien_d, ovr_q, ovr_d, int_q, int_d;
    logic [3:0] irq_q, irq_d;
    logic [7:0] rdata_q, rdata_d, rd_val, tx_head, status, ctrl;
    logic [1:0] ofs;
    logic hit, wr_fire, rd_fire, tx_pop, rx_push, rx_pop, flush;
    logic tx_full, tx_empty, rx_full, rx_empty;
    logic [CW-1:0] tx_count, rx_count;
    logic unused_ok;

    always_ff @(posedge clk_i) begin
        if (!nrst_i) state_q <= LPC_MBOX_ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LPC_MBOX_ST_IDLE:   state_d = lpc_data_wr_i  ? LPC_MBOX_ST_WR_ACK :
                                          lpc_data_req_i ? LPC_MBOX_ST_RD_ACK : LPC_MBOX_ST_IDLE;
            LPC_MBOX_ST_WR_ACK: state_d = lpc_data_wr_i  ? LPC_MBOX_ST_WR_ACK : LPC_MBOX_ST_IDLE;
            LPC_MBOX_ST_RD_ACK: state_d = lpc_data_req_i ? LPC_MBOX_ST_RD_ACK : LPC_MBOX_ST_IDLE;
            default:            state_d = LPC_MBOX_ST_IDLE;
        endcase
    end

    always_comb begin
        hit     = lpc_addr_i[15:2] == BASE_ADDR[15:2];
        ofs     = lpc_addr_i[1:0];
        wr_fire = state_q == LPC_MBOX_ST_IDLE && lpc_data_wr_i;
        rd_fire = state_q == LPC_MBOX_ST_IDLE && !lpc_data_wr_i && lpc_data_req_i;
        rx_pop  = rx_ready_i && !rx_empty;
        rx_push = wr_fire && hit && ofs == LPC_MBOX_OFS_DATA;
        tx_pop  = rd_fire && hit && ofs == LPC_MBOX_OFS_DATA && !tx_empty;
        flush   = wr_fire && hit && ofs == LPC_MBOX_OFS_CTRL && lpc_wdata_i[LPC_MBOX_CTRL_FLUSH];
        status  = 8'h00;
        status[LPC_MBOX_STATUS_TXNE]   = !tx_empty;
        status[LPC_MBOX_STATUS_RXFULL] = rx_full;
        status[LPC_MBOX_STATUS_OVR]    = ovr_q;
        ctrl    = 8'h00;
        ctrl[LPC_MBOX_CTRL_IEN] = ien_q;
        rd_val  = !hit                        ? 8'hFF :
                  ofs == LPC_MBOX_OFS_DATA    ? (tx_empty ? 8'hFF : tx_head) :
                  ofs == LPC_MBOX_OFS_STATUS  ? status :
                  ofs == LPC_MBOX_OFS_CTRL    ? ctrl : {4'b0, irq_q};
        ien_d     = wr_fire && hit && ofs == LPC_MBOX_OFS_CTRL ? lpc_wdata_i[LPC_MBOX_CTRL_IEN] : ien_q;
        irq_d     = wr_fire && hit && ofs == LPC_MBOX_OFS_IRQ ? lpc_wdata_i[3:0] : irq_q;
        ovr_d     = flush                                             ? 1'b0 :
                    rx_push && rx_full && !rx_pop                     ? 1'b1 :
                    rd_fire && hit && ofs == LPC_MBOX_OFS_STATUS      ? 1'b0 : ovr_q;
        rdata_d   = rd_fire ? rd_val : rdata_q;
        wr_done_d = state_d == LPC_MBOX_ST_WR_ACK;
        data_rd_d = state_d == LPC_MBOX_ST_RD_ACK;
        int_d     = ien_q && !tx_empty;
    end

    always_ff @(posedge clk_i) begin
        if (!nrst_i) begin
            wr_done_q <= 1'b0;
            data_rd_q <= 1'b0;
            rdata_q   <= 8'h00;
            ien_q     <= 1'b0;
            ovr_q     <= 1'b0;
            int_q     <= 1'b0;
            irq_q     <= IRQ_DEFAULT;
        end else begin
            wr_done_q <= wr_done_d;
            data_rd_q <= data_rd_d;
            rdata_q   <= rdata_d;
            ien_q     <= ien_d;
            ovr_q     <= ovr_d;
            int_q     <= int_d;
            irq_q     <= irq_d;
        end
    end

    lpc_mbox_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk_i   (clk_i),
        .nrst_i  (nrst_i),
        .push_i  (tx_valid_i && tx_ready_o),
        .data_i  (tx_data_i),
        .pop_i   (tx_pop),
        .flush_i (flush),
        .data_o  (tx_head),
        .full_o  (tx_full),
        .empty_o (tx_empty),
        .count_o (tx_count)
    );

    lpc_mbox_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk_i   (clk_i),
        .nrst_i  (nrst_i),
        .push_i  (rx_push),
        .data_i  (lpc_wdata_i),
        .pop_i   (rx_pop),
        .flush_i (flush),
        .data_o  (rx_data_o),
        .full_o  (rx_full),
        .empty_o (rx_empty),
        .count_o (rx_count)
    );

    assign lpc_wr_done_o = wr_done_q;
    assign lpc_data_rd_o = data_rd_q;
    assign lpc_rdata_o   = rdata_q;
    assign irq_num_o     = irq_q;
    assign interrupt_o   = int_q;
    assign tx_ready_o    = !tx_full;
    assign rx_valid_o    = !rx_empty;
    assign unused_ok     = ^{tx_count, rx_count, lpc_wdata_i[7:4]};
endmodule

// File: tb/tb_lpc_mailbox.sv
// tb_lpc_mailbox: directed plus randomized checks of lpc_mailbox against a queue-based model
module tb_lpc_mailbox;
    localparam logic [15:0] BASE = 16'h0E00;
    localparam int DEPTH = 16;

    logic clk_i = 1'b0;
    logic nrst_i;
    logic [15:0] lpc_addr_i;
    logic [7:0] lpc_wdata_i, lpc_rdata_o, tx_data_i, rx_data_o;
    logic lpc_data_wr_i, lpc_wr_done_o, lpc_data_req_i, lpc_data_rd_o;
    logic [3:0] irq_num_o;
    logic interrupt_o, tx_valid_i, tx_ready_o, rx_valid_o, rx_ready_i;
    logic rnd_en;
    int n_err = 0;
    int n_checks = 0;

    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    logic m_ovr = 1'b0, m_ien = 1'b0, m_wr = 1'b0, m_rd = 1'b0, m_int = 1'b0;
    logic [3:0] m_irq = 4'd5;
    logic [7:0] m_rdata = 8'h00;

    always #5 clk_i = ~clk_i;

    lpc_mailbox dut (
        .clk_i          (clk_i),
        .nrst_i         (nrst_i),
        .lpc_addr_i     (lpc_addr_i),
        .lpc_wdata_i    (lpc_wdata_i),
        .lpc_data_wr_i  (lpc_data_wr_i),
        .lpc_wr_done_o  (lpc_wr_done_o),
        .lpc_data_req_i (lpc_data_req_i),
        .lpc_rdata_o    (lpc_rdata_o),
        .lpc_data_rd_o  (lpc_data_rd_o),
        .irq_num_o      (irq_num_o),
        .interrupt_o    (interrupt_o),
        .tx_data_i      (tx_data_i),
        .tx_valid_i     (tx_valid_i),
        .tx_ready_o     (tx_ready_o),
        .rx_data_o      (rx_data_o),
        .rx_valid_o     (rx_valid_o),
        .rx_ready_i     (rx_ready_i)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic hit, rx_full_pre, tx_ne_pre, flush, tx_push, idle;
        logic [1:0] ofs;
        logic [7:0] v;
        if (!nrst_i) begin
            tx_q.delete();
            rx_q.delete();
            m_ovr = 0; m_ien = 0; m_wr = 0; m_rd = 0; m_int = 0;
            m_irq = 4'd5; m_rdata = 8'h00;
        end else begin
            hit = lpc_addr_i[15:2] == BASE[15:2];
            ofs = lpc_addr_i[1:0];
            idle = !m_wr && !m_rd;
            rx_full_pre = rx_q.size() == DEPTH;
            tx_ne_pre = tx_q.size() != 0;
            flush = 0;
            m_int = m_ien && tx_ne_pre;
            tx_push = tx_valid_i && tx_q.size() < DEPTH;
            if (rx_ready_i && rx_q.size() != 0) void'(rx_q.pop_front());
            if (idle && lpc_data_wr_i) begin
                m_wr = 1;
                if (hit) begin
                    if (ofs == 0) begin
                        if (rx_q.size() < DEPTH) rx_q.push_back(lpc_wdata_i);
                        else m_ovr = 1;
                    end else if (ofs == 2) begin
                        m_ien = lpc_wdata_i[0];
                        flush = lpc_wdata_i[1];
                    end else if (ofs == 3) m_irq = lpc_wdata_i[3:0];
                end
            end else if (idle && lpc_data_req_i) begin
                m_rd = 1;
                v = 8'hFF;
                if (hit) begin
                    if (ofs == 0) begin
                        if (tx_q.size() != 0) v = tx_q.pop_front();
                    end else if (ofs == 1) begin
                        v = {5'b0, m_ovr, rx_full_pre, tx_ne_pre};
                        m_ovr = 0;
                    end else if (ofs == 2) v = {7'b0, m_ien};
                    else v = {4'b0, m_irq};
                end
                m_rdata = v;
            end else begin
                m_wr = m_wr && lpc_data_wr_i;
                m_rd = m_rd && lpc_data_req_i;
            end
            if (tx_push) tx_q.push_back(tx_data_i);
            if (flush) begin
                tx_q.delete();
                rx_q.delete();
                m_ovr = 0;
            end
        end
    endtask

    task automatic compare();
        check("cyc_wr_done", lpc_wr_done_o, m_wr);
        check("cyc_data_rd", lpc_data_rd_o, m_rd);
        check("cyc_rdata", lpc_rdata_o, m_rdata);
        check("cyc_irq_num", irq_num_o, m_irq);
        check("cyc_interrupt", interrupt_o, m_int);
        check("cyc_tx_ready", tx_ready_o, tx_q.size() < DEPTH);
        check("cyc_rx_valid", rx_valid_o, rx_q.size() != 0);
        check("cyc_rx_data", rx_data_o, rx_q.size() != 0 ? rx_q[0] : 8'h00);
    endtask

    initial forever begin
        @(posedge clk_i);
        model_step();
        @(negedge clk_i);
        compare();
    end

    task automatic tick();
        @(posedge clk_i);
        #2;
        if (rnd_en) begin
            tx_valid_i = 1'($urandom_range(0, 1));
            tx_data_i = 8'($urandom);
            rx_ready_i = $urandom_range(0, 2) != 0;
        end
    endtask

    task automatic local_push(input logic [7:0] d);
        tx_valid_i = 1;
        tx_data_i = d;
        tick();
        tx_valid_i = 0;
    endtask

    task automatic host_write(input logic [15:0] a, input logic [7:0] d, input bit with_push);
        lpc_addr_i = a;
        lpc_wdata_i = d;
        lpc_data_wr_i = 1;
        if (with_push) begin
            tx_valid_i = 1;
            tx_data_i = 8'hEE;
        end
        for (int i = 0; i < 8 && !lpc_wr_done_o; i++) begin
            tick();
            if (with_push) tx_valid_i = 0;
        end
        check("wr_done_rise", lpc_wr_done_o, 1);
        repeat ($urandom_range(0, 2)) tick();
        lpc_data_wr_i = 0;
        for (int i = 0; i < 8 && lpc_wr_done_o; i++) tick();
        check("wr_done_fall", lpc_wr_done_o, 0);
    endtask

    task automatic host_read(input logic [15:0] a, output logic [7:0] d);
        lpc_addr_i = a;
        lpc_data_req_i = 1;
        for (int i = 0; i < 8 && !lpc_data_rd_o; i++) tick();
        check("rd_ack_rise", lpc_data_rd_o, 1);
        d = lpc_rdata_o;
        repeat ($urandom_range(0, 2)) tick();
        lpc_data_req_i = 0;
        for (int i = 0; i < 8 && lpc_data_rd_o; i++) tick();
        check("rd_ack_fall", lpc_data_rd_o, 0);
    endtask

    task automatic rd_expect(input logic [15:0] a, input logic [7:0] exp, input string name);
        logic [7:0] d;
        host_read(a, d);
        check(name, d, exp);
    endtask

    initial begin
        nrst_i = 0; lpc_addr_i = 0; lpc_wdata_i = 0; lpc_data_wr_i = 0; lpc_data_req_i = 0;
        tx_data_i = 0; tx_valid_i = 0; rx_ready_i = 0; rnd_en = 0;
        repeat (3) tick();
        check("rst_irq_num", irq_num_o, 4'h5);
        check("rst_tx_ready", tx_ready_o, 1);
        check("rst_rx_valid", rx_valid_o, 0);
        nrst_i = 1;
        tick();

        local_push(8'hA5);
        local_push(8'h3C);
        rd_expect(16'h0E01, 8'h01, "status_txne");
        rd_expect(16'h0E00, 8'hA5, "data_first");
        rd_expect(16'h0E00, 8'h3C, "data_second");
        rd_expect(16'h0E00, 8'hFF, "data_empty");
        rd_expect(16'h0E01, 8'h00, "status_idle");

        for (int i = 0; i <= DEPTH; i++) host_write(16'h0E00, 8'(8'h10 + i), 0);
        rd_expect(16'h0E01, 8'h06, "status_ovr");
        rd_expect(16'h0E01, 8'h02, "status_ovr_clr");
        rx_ready_i = 1;
        for (int i = 0; i < DEPTH; i++) begin
            check("rx_drain_valid", rx_valid_o, 1);
            check("rx_drain_data", rx_data_o, 8'(8'h10 + i));
            tick();
        end
        rx_ready_i = 0;
        check("rx_drained", rx_valid_o, 0);

        host_write(16'h0E02, 8'h01, 0);
        tick();
        check("int_tx_empty", interrupt_o, 0);
        local_push(8'h77);
        check("int_latency", interrupt_o, 0);
        tick();
        check("int_set", interrupt_o, 1);
        rd_expect(16'h0E00, 8'h77, "int_drain");
        tick();
        tick();
        check("int_clr", interrupt_o, 0);

        host_write(16'h0E03, 8'h0B, 0);
        check("irq_num_set", irq_num_o, 4'hB);
        rd_expect(16'h0E03, 8'h0B, "irq_readback");
        rd_expect(16'h1234, 8'hFF, "miss_read");
        host_write(16'h1234, 8'h0F, 0);
        check("miss_wr_irq", irq_num_o, 4'hB);
        rd_expect(16'h0E01, 8'h00, "miss_wr_status");

        for (int i = 0; i < DEPTH; i++) local_push(8'(i));
        check("tx_full_ready", tx_ready_o, 0);
        host_write(16'h0E00, 8'h55, 0);
        host_write(16'h0E00, 8'h66, 0);
        rd_expect(16'h0E00, 8'h00, "pop_before_flush");
        host_write(16'h0E02, 8'h02, 1);
        check("flush_tx_ready", tx_ready_o, 1);
        check("flush_rx_valid", rx_valid_o, 0);
        rd_expect(16'h0E01, 8'h00, "flush_status");

        local_push(8'h42);
        lpc_addr_i = 16'h0E00;
        lpc_data_req_i = 1;
        tick();
        check("rd_before_reset", lpc_data_rd_o, 1);
        nrst_i = 0;
        lpc_data_req_i = 0;
        tick();
        check("rst_mid_rd", lpc_data_rd_o, 0);
        check("rst_mid_rdata", lpc_rdata_o, 8'h00);
        check("rst_mid_irq", irq_num_o, 4'h5);
        check("rst_mid_tx_ready", tx_ready_o, 1);
        nrst_i = 1;
        tick();
        rd_expect(16'h0E01, 8'h00, "post_reset_status");

        rnd_en = 1;
        repeat (500) begin
            logic [15:0] a;
            logic [7:0] d, r;
            a = $urandom_range(0, 7) == 0 ? 16'($urandom) : BASE + 16'($urandom_range(0, 3));
            d = 8'($urandom);
            if (a == BASE + 16'd2 && $urandom_range(0, 7) != 0) d[1] = 1'b0;
            if ($urandom_range(0, 1) == 1) host_write(a, d, 0);
            else host_read(a, r);
            repeat ($urandom_range(0, 2)) tick();
        end
        rnd_en = 0;
        tx_valid_i = 0;
        rx_ready_i = 0;
        tick();
        tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
